// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared definitions for the ring-oscillator frequency meter.
// Holds the measurement FSM state encoding and default sizing constants.
// DEF_NUM_RO matches the oscillator-array top so both sides agree on width.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int DEF_NUM_RO        = 145;
  localparam int DEF_SEL_W         = 8;
  localparam int DEF_CNT_W         = 24;
  localparam int DEF_GATE_W        = 24;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/ro_freq_meter_if.sv
// ro_freq_meter_if: request/result bus of the frequency meter.
//   start/sel/gate_cycles   : measurement request (master -> slave)
//   result_ready            : consumer accepts result (master -> slave)
//   busy/result/result_valid/overflow/sel_err : status and readout (slave -> master)
interface ro_freq_meter_if
  import ro_meas_pkg::*;
#(
  parameter int SEL_W  = DEF_SEL_W,
  parameter int GATE_W = DEF_GATE_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              start;
  logic [SEL_W-1:0]  sel;
  logic [GATE_W-1:0] gate_cycles;
  logic              busy;
  logic [CNT_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;
  logic              overflow;
  logic              sel_err;

  modport master (
    output start, sel, gate_cycles, result_ready,
    input  busy, result, result_valid, overflow, sel_err
  );

  modport slave (
    input  start, sel, gate_cycles, result_ready,
    output busy, result, result_valid, overflow, sel_err
  );

endinterface

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: brings an asynchronous oscillator output into the clk domain
// through SYNC_STAGES flops and emits a one-cycle pulse per rising edge.
//   clk, rst_n : system clock, synchronous active-low reset (clears all flops)
//   d_i        : asynchronous input
//   pulse_o    : high for one clk cycle after each synchronized rising edge
module ro_edge_sync
  import ro_meas_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: enables the ring-oscillator array, muxes one oscillator,
// synchronizes it and counts its rising edges over a gate window of
// gate_cycles clk cycles, after a SETTLE_CYCLES warm-up.
//   clk, rst_n : system clock, synchronous active-low reset
//   ro_in      : raw oscillator outputs (asynchronous)
//   ro_en      : oscillator array enable
//   bus        : request / result handshake (see ro_freq_meter_if)
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int NUM_RO        = DEF_NUM_RO,
  parameter int SEL_W         = DEF_SEL_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int GATE_W        = DEF_GATE_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RO-1:0] ro_in,
  output logic              ro_en,
  ro_freq_meter_if.slave    bus
);

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              sel_err_q, sel_err_d;
  logic              ro_en_q, ro_en_d;
  logic              ro_sel;
  logic              edge_pulse;

  // Saturating increment: returns {overflow, count}. Overflow latches when
  // an edge arrives while the counter already sits at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                              input logic ovf,
                                              input logic pulse);
    logic [CNT_W:0] r;
    r = {ovf, c};
    if (pulse) begin
      if (c == CNT_MAX) r = {1'b1, c};
      else              r = {ovf, c + 1'b1};
    end
    return r;
  endfunction

  assign ro_sel = ro_in[sel_q];

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (ro_sel),
    .pulse_o (edge_pulse)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gate_d    = gate_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    sel_err_d = sel_err_q;
    ro_en_d   = ro_en_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d     = bus.sel;
          gate_d    = bus.gate_cycles;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          if (int'(bus.sel) >= NUM_RO) begin
            sel_err_d = 1'b1;
            result_d  = '0;
            state_d   = HOLD;
          end else begin
            sel_err_d = 1'b0;
            ro_en_d   = 1'b1;
            timer_d   = SETTLE_LAST;
            state_d   = SETTLE;
          end
        end
      end
      SETTLE: begin
        // Warm-up also flushes the synchronizer before the gate opens.
        if (timer_q == '0) begin
          if (gate_q == '0) begin
            result_d = '0;
            ro_en_d  = 1'b0;
            state_d  = HOLD;
          end else begin
            timer_d = gate_q - 1'b1;
            state_d = COUNT;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      COUNT: begin
        {ovf_d, cnt_d} = sat_inc(cnt_q, ovf_q, edge_pulse);
        if (timer_q == '0) begin
          // Last gate cycle: the edge seen this cycle is included.
          result_d = cnt_d;
          ro_en_d  = 1'b0;
          state_d  = HOLD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      HOLD: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      sel_err_q <= 1'b0;
      ro_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      sel_err_q <= sel_err_d;
      ro_en_q   <= ro_en_d;
    end
  end

  // Request operands are pure data; they only matter once latched on start.
  always_ff @(posedge clk) begin
    sel_q  <= sel_d;
    gate_q <= gate_d;
  end

  assign ro_en            = ro_en_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == HOLD);
  assign bus.overflow     = ovf_q;
  assign bus.sel_err      = sel_err_q;

endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
Measurement stage directly downstream of the 3-inverter ring-oscillator array. It drives the array's enable and selects one oscillator output through an internal mux. It synchronizes that output into the system clock domain and counts its rising edges over a programmable gate window. The count is returned with a valid/ready handshake, giving a per-oscillator frequency readout for delay and aging characterisation.

Parameters:
NUM_RO, 145, number of oscillator inputs
SEL_W, 8, width of oscillator select
CNT_W, 24, width of edge counter / result
GATE_W, 24, width of gate-window length
SETTLE_CYCLES, 16, clk cycles between ro_en rising and gate open
SYNC_STAGES, 2, synchronizer flops on selected oscillator

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ro_in  in  NUM_RO  raw oscillator outputs, asynchronous to clk
ro_en  out  1  enable to the oscillator array
start  in  1  single-cycle measurement request, honoured only in IDLE
sel  in  SEL_W  oscillator index, sampled on accepted start
gate_cycles  in  GATE_W  gate length in clk cycles, sampled on accepted start
busy  out  1  high in every state except IDLE
result  out  CNT_W  rising-edge count of the last measurement
result_valid  out  1  result available, held until accepted
result_ready  in  1  consumer accepts result
overflow  out  1  counter saturated during the last gate
sel_err  out  1  last accepted sel was >= NUM_RO

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE and every output 0 on that edge, including ro_en, busy, result, result_valid, overflow and sel_err. A reset in any state aborts the measurement; ro_en is 0 after that edge.
- FSM states: IDLE, SETTLE, COUNT, HOLD.
- IDLE: start=1 latches sel and gate_cycles and clears the counter, overflow and sel_err.
  - If sel >= NUM_RO: go to HOLD with result=0, sel_err=1, ro_en kept 0.
  - Otherwise: go to SETTLE with ro_en=1 from the next cycle.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, which also flushes the synchronizer. Then go to COUNT if gate_cycles != 0. If gate_cycles == 0, go to HOLD with result=0.
- COUNT: lasts exactly gate_cycles cycles.
  - Each cycle with the edge-detect pulse high increments the counter.
  - At all-ones the counter saturates and sets overflow=1.
  - On exit, result takes the final count.
- HOLD: result_valid=1 and ro_en=0.
  - result_valid, result, overflow and sel_err are stable until the cycle where result_valid && result_ready; the next state is then IDLE.
  - start in HOLD, or in the handshake cycle, is ignored. There is no queueing.
- Mux and edge detect: the selected bit ro_in[sel_q] passes through SYNC_STAGES flops. The edge pulse is sync_last & ~sync_prev.
- Latency: accepted start at cycle T → result_valid at T+1+SETTLE_CYCLES+gate_cycles (registered).
- Accuracy: the count is correct only for an oscillator frequency below f_clk/2. Faster oscillators alias, and interpreting such results is software's job.
- sel and gate_cycles changing while busy have no effect.

Decomposition:
- Package ro_meas_pkg:
  - state enum (IDLE, SETTLE, COUNT, HOLD);
  - default widths CNT_W, GATE_W, SEL_W;
  - SETTLE_CYCLES default;
  - NUM_RO=145 constant shared with the oscillator-array top.
- Sub-module ro_edge_sync: SYNC_STAGES synchronizer plus rising-edge pulse generator. Its synchronous rst_n clears all flops to 0.

Test Plan:
- Oscillator model toggling every 4 clk (period 8). start with sel=5, gate_cycles=800 → result=100, overflow=0, sel_err=0, result_valid at T+1+16+800.
- sel=200 → HOLD next cycle, result_valid=1, result=0, sel_err=1, ro_en stays 0 throughout.
- gate_cycles=0, sel=3 → ro_en high for 16 cycles, then result=0, result_valid=1, overflow=0.
- CNT_W=4 override, oscillator period 4 clk, gate_cycles=100 → result=15 (all-ones), overflow=1.
- Hold result_ready=0 for 50 cycles in HOLD, pulsing start repeatedly:
  - result and flags stay stable, no new measurement;
  - ready=1 → IDLE next cycle;
  - a start asserted with ready is ignored.
- rst_n low mid-COUNT for one cycle → next edge: ro_en=0, busy=0, result_valid=0, result=0. A subsequent start measures correctly (result=100 for the first scenario).
